// File: rtl/adder_gp_input_stage_pkg.sv
// rtl/adder_gp_input_stage_pkg.sv - shared width and handshake state definitions for the adder input stage
//
// Contents:
//   LEN_DATA    default operand width
//   gp_state_t  occupancy of the output/skid storage (ST_EMPTY, ST_ONE, ST_FULL)

package adder_gp_input_stage_pkg;

    localparam int LEN_DATA = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } gp_state_t;

endpackage

// File: rtl/adder_gp_bitgen.sv
// rtl/adder_gp_bitgen.sv - combinational per-bit generate/propagate/half-sum for the prefix adder
//
// Ports:
//   a, b      in   WIDTH  operand A and already-conditioned operand B'
//   cin       in   1      effective carry-in
//   g         out  WIDTH  generate, carry-in folded into bit 0
//   p         out  WIDTH  propagate, bit 0 forced to 0
//   half_sum  out  WIDTH  a ^ b for every bit

module adder_gp_bitgen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] half_sum
);

    logic [WIDTH-1:0] g_raw;

    assign half_sum = a ^ b;
    assign g_raw    = a & b;

    // Bit 0 absorbs the carry-in, so the prefix tree never sees cin and
    // bit 0 must not propagate anything further.
    assign g = {g_raw[WIDTH-1:1], g_raw[0] | (half_sum[0] & cin)};
    assign p = {half_sum[WIDTH-1:1], 1'b0};

endmodule

// File: rtl/adder_gp_input_stage.sv
// rtl/adder_gp_input_stage.sv - registered generate/propagate front-end of the parallel-prefix adder
//
// Build option: ADDER_GP_SKID_EN selects the two-entry (output + skid) buffer with a
// fully registered in_ready; when undefined a single output register is used and
// in_ready depends combinationally on out_ready.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid, in_ready                operand handshake
//   op_a, op_b, op_sub, carry_in      operands, subtract select, carry/borrow-in
//   out_valid, out_ready              result handshake
//   generate_out, propogate_out       per-bit generate / propagate
//   half_sum                          A ^ B' for the final sum stage

module adder_gp_input_stage
    import adder_gp_input_stage_pkg::*;
#(
    parameter int WIDTH = LEN_DATA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] generate_out,
    output logic [WIDTH-1:0] propogate_out,
    output logic [WIDTH-1:0] half_sum
);

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH-1:0] g_new, p_new, hs_new;

    assign b_eff = op_sub ? ~op_b : op_b;
    assign cin   = carry_in ^ op_sub;

    adder_gp_bitgen #(.WIDTH(WIDTH)) u_bitgen (
        .a        (op_a),
        .b        (b_eff),
        .cin      (cin),
        .g        (g_new),
        .p        (p_new),
        .half_sum (hs_new)
    );

    gp_state_t        state;
    logic             ready_q;
    logic [WIDTH-1:0] g_q, p_q, hs_q;
    logic             accept, drain;

    assign out_valid     = (state != ST_EMPTY);
    assign generate_out  = g_q;
    assign propogate_out = p_q;
    assign half_sum      = hs_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

`ifdef ADDER_GP_SKID_EN
    logic [WIDTH-1:0] g_s, p_s, hs_s;

    // ready_q is cleared by reset so in_ready stays low for one cycle after
    // reset is released; rst gating keeps it low during reset itself.
    assign in_ready = ready_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
            g_q     <= '0;
            p_q     <= '0;
            hs_q    <= '0;
            g_s     <= '0;
            p_s     <= '0;
            hs_s    <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        g_q   <= g_new;
                        p_q   <= p_new;
                        hs_q  <= hs_new;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        g_q  <= g_new;
                        p_q  <= p_new;
                        hs_q <= hs_new;
                    end else if (accept) begin
                        g_s     <= g_new;
                        p_s     <= p_new;
                        hs_s    <= hs_new;
                        state   <= ST_FULL;
                        ready_q <= 1'b0;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        g_q   <= g_s;
                        p_q   <= p_s;
                        hs_q  <= hs_s;
                        state <= ST_ONE;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end
`else
    // Single register: a new beat may enter whenever the current one leaves.
    assign in_ready = ready_q & ~rst & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
            g_q     <= '0;
            p_q     <= '0;
            hs_q    <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                g_q   <= g_new;
                p_q   <= p_new;
                hs_q  <= hs_new;
                state <= ST_ONE;
            end else if (drain) begin
                state <= ST_EMPTY;
            end
        end
    end
`endif

endmodule
